ifu: RTL and testbench

Instruction fetch unit for the single-cycle MIPS core. It is the requesting side of the instruction-memory read interface: it holds the PC, drives the word address into instruction memory, and returns the fetched word to decode. It also computes the next PC for sequential, branch, jump and jump-register flow. It detects illegal fetch targets and halts fetch cleanly.

---
 rtl/ifu.sv | 103 ++++++++++
 tb/tb_ifu.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/ifu.sv
// Instruction fetch unit for the single-cycle MIPS core: holds the PC, addresses
// instruction memory, computes next PC and halts cleanly on an illegal fetch target.
module ifu #(
  parameter logic [31:0] PC_RESET = 32'h0000_3000,
  parameter logic [31:0] IM_BASE  = 32'h0000_3000,
  parameter int unsigned IM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [1:0]  npc_sel,
  input  logic        br_taken,
  input  logic [31:0] ra_value,
  input  logic [31:0] im_data,
  output logic [9:0]  im_addr,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] instr,
  output logic        fault,
  output logic [31:0] fault_pc,
  output logic [31:0] fetch_cnt
);

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_e;

  // Upper bound is kept in 33 bits so a window ending at 2^32 still compares correctly.
  localparam logic [32:0] IM_LO = {1'b0, IM_BASE};
  localparam logic [32:0] IM_HI = IM_LO + (33'(IM_WORDS) << 2);

  state_e      state_q,     state_d;
  logic [31:0] pc_q,        pc_d;
  logic        fault_q,     fault_d;
  logic [31:0] fault_pc_q,  fault_pc_d;
  logic [31:0] fetch_cnt_q, fetch_cnt_d;

  logic [31:0] br_off;
  logic [31:0] tgt;
  logic [32:0] tgt_ext;
  logic        tgt_legal;

  // Only the low 12 bits of (pc - IM_BASE) reach the word index.
  assign im_addr   = 10'((pc_q[11:0] - IM_BASE[11:0]) >> 2);
  assign pc_plus4  = pc_q + 32'd4;
  assign instr     = (state_q == HALT) ? '0 : im_data;
  assign pc        = pc_q;
  assign fault     = fault_q;
  assign fault_pc  = fault_pc_q;
  assign fetch_cnt = fetch_cnt_q;

  assign br_off = {{14{instr[15]}}, instr[15:0], 2'b00};

  always_comb begin
    tgt = pc_plus4;
    unique case (npc_sel)
      2'b00: tgt = pc_plus4;
      2'b01: tgt = br_taken ? (pc_plus4 + br_off) : pc_plus4;
      2'b10: tgt = {pc_plus4[31:28], instr[25:0], 2'b00};
      2'b11: tgt = ra_value;
    endcase
  end

  assign tgt_ext   = {1'b0, tgt};
  assign tgt_legal = (tgt[1:0] == 2'b00) && (tgt_ext >= IM_LO) && (tgt_ext < IM_HI);

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    fault_d     = fault_q;
    fault_pc_d  = fault_pc_q;
    fetch_cnt_d = fetch_cnt_q;
    if (state_q == RUN && !stall) begin
      // The faulting instruction still retires, so the count advances either way.
      fetch_cnt_d = fetch_cnt_q + 32'd1;
      if (tgt_legal) begin
        pc_d = tgt;
      end else begin
        state_d    = HALT;
        fault_d    = 1'b1;
        fault_pc_d = tgt;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= RUN;
      pc_q        <= PC_RESET;
      fault_q     <= 1'b0;
      fault_pc_q  <= '0;
      fetch_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      fault_q     <= fault_d;
      fault_pc_q  <= fault_pc_d;
      fetch_cnt_q <= fetch_cnt_d;
    end
  end

endmodule

// File: tb/tb_ifu.sv
// Directed bench for ifu: sequential, branch, jump, jr, stall, fault and reset cases
// with hand-computed expectations.
module tb_ifu;

  logic        clk;
  logic        reset;
  logic        stall;
  logic [1:0]  npc_sel;
  logic        br_taken;
  logic [31:0] ra_value;
  logic [31:0] im_data;
  logic [9:0]  im_addr;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] instr;
  logic        fault;
  logic [31:0] fault_pc;
  logic [31:0] fetch_cnt;

  int unsigned n_checks;
  int unsigned n_errors;

  ifu #(
    .PC_RESET(32'h0000_3000),
    .IM_BASE (32'h0000_3000),
    .IM_WORDS(1024)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .stall    (stall),
    .npc_sel  (npc_sel),
    .br_taken (br_taken),
    .ra_value (ra_value),
    .im_data  (im_data),
    .im_addr  (im_addr),
    .pc       (pc),
    .pc_plus4 (pc_plus4),
    .instr    (instr),
    .fault    (fault),
    .fault_pc (fault_pc),
    .fetch_cnt(fetch_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string tag, input logic [31:0] e_pc, input logic e_fault,
                             input logic [31:0] e_fpc, input logic [31:0] e_cnt);
    check({tag, ".pc"},        pc,                e_pc);
    check({tag, ".fault"},     {31'd0, fault},    {31'd0, e_fault});
    check({tag, ".fault_pc"},  fault_pc,          e_fpc);
    check({tag, ".fetch_cnt"}, fetch_cnt,         e_cnt);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset    = 1'b1;
    stall    = 1'b0;
    npc_sel  = 2'b00;
    br_taken = 1'b0;
    ra_value = '0;
    im_data  = 32'h1234_5678;

    do_reset();
    check_state("reset", 32'h3000, 1'b0, 32'h0, 32'd0);
    check("reset.im_addr", {22'd0, im_addr}, 32'd0);
    check("reset.instr", instr, 32'h1234_5678);

    // Sequential fetch
    tick(); check("seq1.pc", pc, 32'h3004); check("seq1.im_addr", {22'd0, im_addr}, 32'd1);
    tick(); check("seq2.pc", pc, 32'h3008); check("seq2.im_addr", {22'd0, im_addr}, 32'd2);
    tick(); check("seq3.pc", pc, 32'h300C); check("seq3.im_addr", {22'd0, im_addr}, 32'd3);
    check("seq3.fetch_cnt", fetch_cnt, 32'd3);

    // Taken branch backwards from 3008
    do_reset(); tick(); tick();
    check("br.pre_pc", pc, 32'h3008);
    im_data = 32'h1000_FFFE; npc_sel = 2'b01; br_taken = 1'b1;
    tick();
    check_state("br_taken", 32'h3004, 1'b0, 32'h0, 32'd3);

    // Stall two cycles at 3004 with an illegal jr target pending
    stall = 1'b1; npc_sel = 2'b11; ra_value = 32'h0000_3002;
    for (int i = 0; i < 2; i++) begin
      tick();
      check_state("stall", 32'h3004, 1'b0, 32'h0, 32'd3);
      check("stall.im_addr", {22'd0, im_addr}, 32'd1);
    end
    stall = 1'b0; npc_sel = 2'b00;
    tick();
    check_state("unstall", 32'h3008, 1'b0, 32'h0, 32'd4);

    // Not-taken branch at 3008
    im_data = 32'h1000_FFFE; npc_sel = 2'b01; br_taken = 1'b0;
    tick();
    check_state("br_not", 32'h300C, 1'b0, 32'h0, 32'd5);

    // j to 3014
    im_data = 32'h0800_0C05; npc_sel = 2'b10;
    tick();
    check_state("j", 32'h3014, 1'b0, 32'h0, 32'd6);
    check("j.pc_plus4", pc_plus4, 32'h3018);
    check("j.im_addr", {22'd0, im_addr}, 32'd5);

    // jr to 3010
    npc_sel = 2'b11; ra_value = 32'h0000_3010;
    tick();
    check_state("jr", 32'h3010, 1'b0, 32'h0, 32'd7);

    // Misaligned jr faults; halt holds against varied inputs
    ra_value = 32'h0000_3002; im_data = 32'hDEAD_BEEF;
    tick();
    check_state("mis", 32'h3010, 1'b1, 32'h3002, 32'd8);
    check("mis.instr", instr, 32'h0);
    for (int i = 0; i < 5; i++) begin
      npc_sel = 2'(i); ra_value = 32'h0000_3020; br_taken = 1'b1; stall = i[0];
      tick();
      check_state("halt", 32'h3010, 1'b1, 32'h3002, 32'd8);
      check("halt.instr", instr, 32'h0);
    end
    stall = 1'b0;

    // Reset out of HALT
    do_reset();
    check_state("rst_halt", 32'h3000, 1'b0, 32'h0, 32'd0);
    check("rst_halt.instr", instr, 32'hDEAD_BEEF);

    // Out-of-range jr
    npc_sel = 2'b11; ra_value = 32'h0000_4000;
    tick();
    check_state("oor", 32'h3000, 1'b1, 32'h4000, 32'd1);

    // Below-base jr
    do_reset();
    ra_value = 32'h0000_2FFC;
    tick();
    check_state("below", 32'h3000, 1'b1, 32'h2FFC, 32'd1);

    // Reset while stalled
    do_reset(); npc_sel = 2'b00; tick();
    check("pre_rst_stall.pc", pc, 32'h3004);
    stall = 1'b1; reset = 1'b1;
    tick();
    reset = 1'b0; stall = 1'b0;
    check_state("rst_stall", 32'h3000, 1'b0, 32'h0, 32'd0);

    // Fall-through off the last word
    npc_sel = 2'b11; ra_value = 32'h0000_3FFC;
    tick();
    check_state("last", 32'h3FFC, 1'b0, 32'h0, 32'd1);
    check("last.im_addr", {22'd0, im_addr}, 32'h3FF);
    npc_sel = 2'b00;
    tick();
    check_state("fall", 32'h3FFC, 1'b1, 32'h4000, 32'd2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
